// File: rtl/s_axis_rx.sv
// s_axis_rx: AXI-Stream slave receiver feeding a first-word-fall-through FIFO.
// Accepts TVALID/TREADY beats from an upstream master and buffers them
// for the systolic-array load logic. It also reports the fill level and a
// running count of accepted beats.
// Optional feature macro: S_AXIS_RX_TLAST_EN adds the TLAST input and the
// data_last and pkt_done outputs. With the macro set, each FIFO entry also
// stores the TLAST bit.
module s_axis_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  TVALID,
  output logic                  TREADY,
  input  logic [DATA_WIDTH-1:0] TDATA,
`ifdef S_AXIS_RX_TLAST_EN
  input  logic                  TLAST,
  output logic                  data_last,
  output logic                  pkt_done,
`endif
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_rd,
  output logic [ADDR_WIDTH:0]   fill,
  output logic [15:0]           beat_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);

`ifdef S_AXIS_RX_TLAST_EN
  localparam int ENTRY_WIDTH = DATA_WIDTH + 1;
`else
  localparam int ENTRY_WIDTH = DATA_WIDTH;
`endif

  typedef enum logic {
    WAIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     fill_q, fill_d;
  logic [15:0]             beat_cnt_q, beat_cnt_d;
  logic                    pkt_done_q, pkt_done_d;
  logic [ENTRY_WIDTH-1:0]  mem_q [DEPTH];
  logic [ENTRY_WIDTH-1:0]  wr_entry;
  logic [ENTRY_WIDTH-1:0]  head_entry;
  logic                    push;
  logic                    pop;
  logic                    not_empty;

  // TREADY depends only on registered state, so it never combinationally follows TVALID or data_rd.
  assign TREADY    = (state_q == RUN) && (fill_q != FULL_LEVEL);
  assign not_empty = (fill_q != '0);
  assign push      = TVALID && TREADY;
  assign pop       = data_rd && not_empty;

`ifdef S_AXIS_RX_TLAST_EN
  assign wr_entry  = {TLAST, TDATA};
  assign data_last = not_empty ? head_entry[DATA_WIDTH] : 1'b0;
  assign pkt_done  = pkt_done_q;
`else
  assign wr_entry  = TDATA;
`endif

  // Head entry falls through to the outputs; masked to zero while empty so reset values are clean.
  assign head_entry = mem_q[rd_ptr_q];
  assign data_out   = not_empty ? head_entry[DATA_WIDTH-1:0] : '0;
  assign data_valid = not_empty;
  assign fill       = fill_q;
  assign beat_cnt   = beat_cnt_q;

  // Next-state logic for the control FSM, pointers, occupancy and statistics.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    beat_cnt_d = beat_cnt_q;
    pkt_done_d = 1'b0;

    case (state_q)
      WAIT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = WAIT;
    endcase

    if (push) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      beat_cnt_d = beat_cnt_q + 16'd1;
`ifdef S_AXIS_RX_TLAST_EN
      pkt_done_d = TLAST;
`endif
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // Control and status registers, cleared asynchronously so a reset discards the FIFO contents at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      beat_cnt_q <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // FIFO storage is written on accepted beats only; its contents are never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_s_axis_rx.sv
// tb_s_axis_rx: directed testbench for s_axis_rx (DATA_WIDTH=8, ADDR_WIDTH=2).
// The TLAST section is built only when S_AXIS_RX_TLAST_EN is defined.
module tb_s_axis_rx;

  logic        clk;
  logic        reset_n;
  logic        TVALID;
  logic        TREADY;
  logic [7:0]  TDATA;
`ifdef S_AXIS_RX_TLAST_EN
  logic        TLAST;
  logic        data_last;
  logic        pkt_done;
`endif
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_rd;
  logic [2:0]  fill;
  logic [15:0] beat_cnt;

  int checkCount;
  int failCount;
  int expBeats;

  s_axis_rx #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .TVALID     (TVALID),
    .TREADY     (TREADY),
    .TDATA      (TDATA),
`ifdef S_AXIS_RX_TLAST_EN
    .TLAST      (TLAST),
    .data_last  (data_last),
    .pkt_done   (pkt_done),
`endif
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_rd    (data_rd),
    .fill       (fill),
    .beat_cnt   (beat_cnt)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a failure with observed and expected values.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advances one rising edge and settles 1 unit after it, away from the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence.
  initial begin
    logic [7:0] fullVals [5];
    checkCount = 0;
    failCount  = 0;
    expBeats   = 0;
    fullVals   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    reset_n = 1'b0;
    TVALID  = 1'b0;
    TDATA   = 8'h00;
    data_rd = 1'b0;
`ifdef S_AXIS_RX_TLAST_EN
    TLAST   = 1'b0;
`endif

    // Reset held for 5 cycles.
    repeat (5) applyStimulus();
    checkOutput("rst_tready", 32'(TREADY), 32'd0);
    checkOutput("rst_valid", 32'(data_valid), 32'd0);
    checkOutput("rst_fill", 32'(fill), 32'd0);
    checkOutput("rst_beatcnt", 32'(beat_cnt), 32'd0);
    checkOutput("rst_dataout", 32'(data_out), 32'd0);

    // Release: TREADY stays low until the first edge moves the FSM to RUN.
    reset_n = 1'b1;
    #1;
    checkOutput("rel_tready_pre", 32'(TREADY), 32'd0);
    applyStimulus();
    checkOutput("rel_tready_post", 32'(TREADY), 32'd1);
    checkOutput("rel_fill", 32'(fill), 32'd0);

    // Pop while empty has no effect.
    data_rd = 1'b1;
    applyStimulus();
    checkOutput("empty_rd_fill", 32'(fill), 32'd0);
    checkOutput("empty_rd_valid", 32'(data_valid), 32'd0);

    // Push and pop together while empty: the push wins and the pop is ignored.
    TVALID = 1'b1;
    TDATA  = 8'h5A;
    applyStimulus();
    expBeats++;
    checkOutput("empty_both_fill", 32'(fill), 32'd1);
    checkOutput("empty_both_data", 32'(data_out), 32'h5A);
    checkOutput("empty_both_valid", 32'(data_valid), 32'd1);
    checkOutput("empty_both_cnt", 32'(beat_cnt), 32'(expBeats));
    TVALID = 1'b0;
    applyStimulus();
    checkOutput("drain_fill", 32'(fill), 32'd0);
    data_rd = 1'b0;

    // Fill to full.
    TVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      TDATA = fullVals[i];
      applyStimulus();
      expBeats++;
    end
    checkOutput("full_fill", 32'(fill), 32'd4);
    checkOutput("full_tready", 32'(TREADY), 32'd0);
    checkOutput("full_head", 32'(data_out), 32'h11);

    // A fifth beat is held off while full.
    TDATA = 8'h55;
    repeat (2) applyStimulus();
    checkOutput("full_hold_fill", 32'(fill), 32'd4);
    checkOutput("full_hold_cnt", 32'(beat_cnt), 32'(expBeats));

    // A pop while full frees a slot; TREADY rises only on the next cycle.
    data_rd = 1'b1;
    applyStimulus();
    checkOutput("full_pop_fill", 32'(fill), 32'd3);
    checkOutput("full_pop_tready", 32'(TREADY), 32'd1);
    checkOutput("full_pop_head", 32'(data_out), 32'h22);
    data_rd = 1'b0;
    applyStimulus();
    expBeats++;
    checkOutput("refill_fill", 32'(fill), 32'd4);
    checkOutput("refill_cnt", 32'(beat_cnt), 32'(expBeats));
    TVALID = 1'b0;

    // Drain in order.
    data_rd = 1'b1;
    for (int i = 1; i < 5; i++) begin
      checkOutput($sformatf("drain_%0d", i), 32'(data_out), 32'(fullVals[i]));
      applyStimulus();
    end
    checkOutput("drained_fill", 32'(fill), 32'd0);
    checkOutput("drained_valid", 32'(data_valid), 32'd0);
    data_rd = 1'b0;

    // Streaming 20 beats with a push and a pop every cycle.
    TVALID  = 1'b1;
    data_rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      TDATA = 8'(i);
      applyStimulus();
      expBeats++;
      checkOutput($sformatf("stream_data_%0d", i), 32'(data_out), 32'(i));
      checkOutput($sformatf("stream_fill_%0d", i), 32'(fill), 32'd1);
    end
    TVALID = 1'b0;
    applyStimulus();
    data_rd = 1'b0;
    checkOutput("stream_end_fill", 32'(fill), 32'd0);
    checkOutput("stream_cnt", 32'(beat_cnt), 32'(expBeats));

`ifdef S_AXIS_RX_TLAST_EN
    // Three-beat packet with TLAST on the final beat.
    TVALID = 1'b1;
    TDATA  = 8'hA0;
    TLAST  = 1'b0;
    applyStimulus();
    checkOutput("pkt_done_a0", 32'(pkt_done), 32'd0);
    TDATA = 8'hA1;
    applyStimulus();
    checkOutput("pkt_done_a1", 32'(pkt_done), 32'd0);
    TDATA = 8'hA2;
    TLAST = 1'b1;
    applyStimulus();
    checkOutput("pkt_done_a2", 32'(pkt_done), 32'd1);
    TVALID = 1'b0;
    TLAST  = 1'b0;
    applyStimulus();
    expBeats += 3;
    checkOutput("pkt_done_after", 32'(pkt_done), 32'd0);
    checkOutput("pkt_head_a0_last", 32'(data_last), 32'd0);
    data_rd = 1'b1;
    applyStimulus();
    checkOutput("pkt_head_a1", 32'(data_out), 32'hA1);
    checkOutput("pkt_head_a1_last", 32'(data_last), 32'd0);
    applyStimulus();
    checkOutput("pkt_head_a2", 32'(data_out), 32'hA2);
    checkOutput("pkt_head_a2_last", 32'(data_last), 32'd1);
    applyStimulus();
    data_rd = 1'b0;
    checkOutput("pkt_empty_last", 32'(data_last), 32'd0);
    checkOutput("pkt_cnt", 32'(beat_cnt), 32'(expBeats));
`endif

    // Asynchronous reset mid-stream with three beats buffered.
    TVALID = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      TDATA = 8'(i);
      applyStimulus();
    end
    TVALID = 1'b0;
    checkOutput("pre_reset_fill", 32'(fill), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_tready", 32'(TREADY), 32'd0);
    checkOutput("async_valid", 32'(data_valid), 32'd0);
    checkOutput("async_fill", 32'(fill), 32'd0);
    checkOutput("async_cnt", 32'(beat_cnt), 32'd0);
    checkOutput("async_data", 32'(data_out), 32'd0);
    applyStimulus();
    reset_n = 1'b1;
    applyStimulus();
    checkOutput("rerun_tready", 32'(TREADY), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
